psw_programmer: RTL

- Enrollment FSM that writes a new 4-digit password for the password checker FSM.
- The user presses start, keys in 4 digits on the switches and strobes each one, then keys the same 4 digits again to confirm.
- On a match, the block commits the new digits to its output registers, which drive the checker's password digits.
- Sits beside the checker FSM in the board wrapper and is clocked by the divided clock.

---
 rtl/psw_programmer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/psw_programmer.sv
// -----------------------------------------------------------------------------
// psw_programmer
//
// Enrollment FSM that writes a new 4-digit password for the password checker.
// The user asserts start_prog, strobes in four digits on the switches, then
// strobes the same four digits again to confirm. On a match the new digits are
// committed to psw_d1..psw_d4, which feed the checker's password inputs.
//
// Handshake: a digit is offered by placing it on input_psw and raising enable.
// It is taken exactly once, on the first clock where enable is high after
// having been low (strobe = enable & ~enable_q). There is no back-pressure.
// Strobes are ignored in IDLE and CHECK.
//
// Ports:
//   clk          divided system clock
//   rst          synchronous, active-high reset
//   start_prog   level; begins or restarts enrollment (wins over a strobe)
//   enable       digit strobe, rising-edge detected
//   input_psw    digit value from the switches
//   psw_d1..4    committed password digits
//   psw_status   00 idle, 01 last enrollment OK, 10 last enrollment error,
//                11 busy
//   digit_cnt    digits accepted in the current phase, 0..4
//   state_dbg    current FSM state (IDLE=0, ENTER=1, CONFIRM=2, CHECK=3)
//
// Optional feature (macro PSW_PROG_TIMEOUT_EN):
//   An idle counter aborts an enrollment that sees no strobe for TIMEOUT
//   cycles while in ENTER or CONFIRM. Without the macro no counter exists and
//   enrollment waits indefinitely.
// -----------------------------------------------------------------------------
module psw_programmer #(
  parameter logic [3:0] PW_D1     = 4'd7,
  parameter logic [3:0] PW_D2     = 4'd1,
  parameter logic [3:0] PW_D3     = 4'd1,
  parameter logic [3:0] PW_D4     = 4'd7,
  parameter logic [3:0] MAX_DIGIT = 4'd9,
  parameter int         TIMEOUT   = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_prog,
  input  logic       enable,
  input  logic [3:0] input_psw,
  output logic [3:0] psw_d1,
  output logic [3:0] psw_d2,
  output logic [3:0] psw_d3,
  output logic [3:0] psw_d4,
  output logic [1:0] psw_status,
  output logic [2:0] digit_cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    CONFIRM = 2'd2,
    CHECK   = 2'd3
  } state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OK   = 2'b01;
  localparam logic [1:0] ST_ERR  = 2'b10;
  localparam logic [1:0] ST_BUSY = 2'b11;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] status_q, status_d;
  logic [3:0] d1_q, d2_q, d3_q, d4_q;
  logic [3:0] d1_d, d2_d, d3_d, d4_d;
  logic [3:0] temp_q [4];
  logic [3:0] temp_d [4];
  logic       mism_q, mism_d;
  logic       enable_q;

  logic       strobe;
  logic       digit_bad;
  logic [1:0] idx;
  logic       timeout_hit;

  assign strobe    = enable & ~enable_q;
  assign digit_bad = (input_psw > MAX_DIGIT);
  assign idx       = cnt_q[1:0];

`ifdef PSW_PROG_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;

  // Counts cycles without a strobe while an enrollment is in progress.
  // Outside ENTER/CONFIRM it sits at zero, so entry to ENTER starts from 0.
  always_comb begin
    idle_d = '0;
    if (state_q == ENTER || state_q == CONFIRM) begin
      if (start_prog || strobe) idle_d = '0;
      else                      idle_d = idle_q + 1'b1;
    end
  end

  // Checked ahead of the strobe, so a strobe on the limit cycle still aborts.
  assign timeout_hit = (idle_q == IW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    mism_d   = mism_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    d3_d     = d3_q;
    d4_d     = d4_q;
    temp_d   = temp_q;

    case (state_q)
      IDLE: begin
        if (start_prog) begin
          state_d  = ENTER;
          cnt_d    = 3'd0;
          status_d = ST_BUSY;
          mism_d   = 1'b0;
        end
      end

      ENTER, CONFIRM: begin
        if (start_prog) begin
          // Restart; any same-cycle strobe is discarded.
          state_d  = ENTER;
          cnt_d    = 3'd0;
          status_d = ST_BUSY;
          mism_d   = 1'b0;
        end else if (timeout_hit || (strobe && digit_bad)) begin
          state_d  = IDLE;
          cnt_d    = 3'd0;
          status_d = ST_ERR;
        end else if (strobe) begin
          if (state_q == ENTER) begin
            temp_d[idx] = input_psw;
            if (cnt_q == 3'd3) begin
              state_d = CONFIRM;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            mism_d = mism_q | (input_psw != temp_q[idx]);
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd3) state_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (start_prog) begin
          state_d  = ENTER;
          cnt_d    = 3'd0;
          status_d = ST_BUSY;
          mism_d   = 1'b0;
        end else begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          if (mism_q) begin
            status_d = ST_ERR;
          end else begin
            status_d = ST_OK;
            d1_d     = temp_q[0];
            d2_d     = temp_q[1];
            d3_d     = temp_q[2];
            d4_d     = temp_q[3];
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      status_q <= ST_IDLE;
      mism_q   <= 1'b0;
      d1_q     <= PW_D1;
      d2_q     <= PW_D2;
      d3_q     <= PW_D3;
      d4_q     <= PW_D4;
      for (int i = 0; i < 4; i++) temp_q[i] <= 4'd0;
      // Held at 1 so an enable kept high through reset is not a strobe.
      enable_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      mism_q   <= mism_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      d3_q     <= d3_d;
      d4_q     <= d4_d;
      for (int i = 0; i < 4; i++) temp_q[i] <= temp_d[i];
      enable_q <= enable;
    end
  end

  assign psw_d1     = d1_q;
  assign psw_d2     = d2_q;
  assign psw_d3     = d3_q;
  assign psw_d4     = d4_q;
  assign psw_status = status_q;
  assign digit_cnt  = cnt_q;
  assign state_dbg  = state_q;

endmodule
